wb_arbiter_rr: RTL and testbench
================================

# wb_arbiter_rr

Parametrised writeback arbiter between the execute units and the register-file write ports. It drives `NUM_WB` write ports from `NUM_FIX` fixed-latency units (ALU, BRU class) and `NUM_VAR` variable-latency units (LSU, MUL, DIV class).
- Fixed-latency results always win and pass straight through.
- Each variable-latency result is captured in a per-channel FIFO and drained round-robin into the ports the fixed units leave free.
- A starvation watchdog and FIFO back-pressure drive `o_stall` to the front end.

## Interface
Parameters:
- `NUM_FIX`, 2: number of fixed-latency channels, no handshake.
- `NUM_VAR`, 3: number of variable-latency channels, valid/ready handshake.
- `NUM_WB`, 1: number of register-file write ports (1..4).
- `BUF_DEPTH`, 2: FIFO depth per variable channel, power of two, ≥2.
- `STARVE_LIMIT`, 8: consecutive un-granted cycles before a starvation stall (≥1).

Ports:
- `i_clk` in 1: clock. One clock only.
- `i_rst` in 1: reset, synchronous, active-high.
- `i_fix_pkg` in `pipe_t [NUM_FIX]`: fixed-latency results. Request = `valid & wren`.
- `i_var_pkg` in `pipe_t [NUM_VAR]`: variable-latency results. Request = `valid & wren`.
- `o_var_ready` out `[NUM_VAR]`: channel FIFO can accept this cycle.
- `o_wb_pkg` out `pipe_t [NUM_WB]`: write-port payloads. An all-zero package means the port is idle.
- `o_stall` out 1: front-end stall request.
- `o_conflict` out 1: sticky error, fixed requests exceeded `NUM_WB`.

## Operation
- **Var enqueue:** a channel is pushed when its request and `o_var_ready[i]` are both high. `o_var_ready[i] = !full[i]`. A request while `o_var_ready[i]` is low is held by the producer and must stay stable.
- **Fixed allocation:**
  - Valid fixed requests take ports 0..`NUM_WB`-1 in ascending channel order, combinationally, in the same cycle.
  - Surplus fixed requests are dropped and set `o_conflict`.
  - `o_conflict` clears only on reset.
- **Var allocation:**
  - Free ports = `NUM_WB` minus the number of fixed requests granted.
  - Non-empty FIFO heads are scanned starting at `rr_ptr`, wrapping modulo `NUM_VAR`.
  - Up to "free ports" heads are granted to the next free ports in ascending port order.
  - Each granted FIFO pops at the clock edge.
- **Round-robin pointer:**
  - `rr_ptr` ← (last granted channel + 1) mod `NUM_VAR`.
  - `rr_ptr` is unchanged when nothing is granted.
- **Starvation counter:**
  - Counts cycles in which at least one FIFO is non-empty and no var grant occurs.
  - Resets to 0 on any var grant or when all FIFOs are empty.
  - Saturates at `STARVE_LIMIT`.
- **`o_stall`** = (counter == `STARVE_LIMIT`) OR (any FIFO count ≥ `BUF_DEPTH`-1).
- **Front-end contract:** the front end stops issuing fixed-latency ops while `o_stall` is high. Fixed ops already in flight are still accepted.
- **Ordering:** packages from the same channel leave in arrival order. No ordering is guaranteed across channels; the hazard logic owns that.

## Timing
- Fixed path: 0-cycle latency, combinational input to `o_wb_pkg`.
- Var path: minimum 1-cycle latency. A package enqueued at edge N can appear on `o_wb_pkg` in cycle N+1. There is no bypass.
- Simultaneous push and pop on a full FIFO is not allowed: `o_var_ready` is low when the FIFO is full, regardless of any pop in that cycle.
- Simultaneous push and pop on a non-full FIFO: the count is unchanged.
- FIFO pointers wrap modulo `BUF_DEPTH`. The count is `$clog2(BUF_DEPTH)+1` bits wide.
- `o_stall` is combinational from registered state (counter, FIFO counts) only. It has no path from any input.
- While `i_rst` is high (and on the first cycle after its edge):
  - all FIFOs are empty; `rr_ptr` = 0; starve counter = 0;
  - `o_var_ready` = 0, `o_wb_pkg` all zero, `o_stall` = 0, `o_conflict` = 0.
- Reset asserted mid-operation flushes all buffered packages. Nothing is written back.

## Configuration
- Macro `WB_ARB_PERF_EN`.
- **Defined:**
  - Adds output `o_perf_stall_cnt` (32 bit): counts cycles with `o_stall` high.
  - Adds output `o_perf_starve_cnt` (32 bit): counts rising edges of the starvation condition.
  - Both counters wrap at 2^32 and are 0 on reset.
- **Undefined:** the ports and counters are absent. Functional behaviour is identical.

## Test plan
- **Fixed pass-through:** `NUM_WB`=1; ALU request only, rd=5 → `o_wb_pkg[0]` equals the ALU package in the same cycle; all `o_var_ready`=1.
- **Round-robin fairness:** `NUM_WB`=1; LSU, MUL and DIV each enqueue 1 package in cycle 0 with no fixed traffic → write order LSU, MUL, DIV in cycles 1, 2, 3. Repeating the burst starts from LSU (`rr_ptr` back at 0).
- **Back-pressure:** `BUF_DEPTH`=2; 3 MUL pushes while the ALU holds the port every cycle → `o_stall`=1 after the 1st push. `o_var_ready[MUL]`=0 after the 2nd push, and the 3rd push is held. When the ALU idles, MUL packages drain one per cycle.
- **Starvation:** `STARVE_LIMIT`=4; DIV buffered while the ALU holds the port → `o_stall` rises exactly 4 cycles after the enqueue edge and falls in the cycle after the DIV grant.
- **Conflict and multi-port:** `NUM_WB`=2, both fixed channels valid plus LSU buffered → ports get ALU and BRU, the LSU waits, `o_conflict`=0. With `NUM_WB`=1 and both fixed valid → `o_conflict`=1 and stays 1 until `i_rst`.
- **Reset mid-flight:** 2 packages buffered, `i_rst` pulsed for 1 cycle → no writeback of either package. All outputs are at their reset values, and `o_perf_*` = 0 with `WB_ARB_PERF_EN` defined.

Source files
------------

// File: rtl/wb_arbiter_rr.sv
// Writeback arbiter: fixed-latency results pass straight to the write ports, variable-latency
// results are buffered per channel and drained round-robin. Macro WB_ARB_PERF_EN adds perf counters.
package wb_arbiter_rr_pkg;
    typedef struct packed {
        logic        valid;
        logic        wren;
        logic [4:0]  rd;
        logic [31:0] data;
    } pipe_t;
endpackage

module wb_arbiter_rr
    import wb_arbiter_rr_pkg::*;
#(
    parameter int NUM_FIX      = 2,
    parameter int NUM_VAR      = 3,
    parameter int NUM_WB       = 1,
    parameter int BUF_DEPTH    = 2,
    parameter int STARVE_LIMIT = 8
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  pipe_t              i_fix_pkg [NUM_FIX],
    input  pipe_t              i_var_pkg [NUM_VAR],
    output logic [NUM_VAR-1:0] o_var_ready,
    output pipe_t              o_wb_pkg [NUM_WB],
    output logic               o_stall,
    output logic               o_conflict
`ifdef WB_ARB_PERF_EN
    ,
    output logic [31:0]        o_perf_stall_cnt,
    output logic [31:0]        o_perf_starve_cnt
`endif
);
    localparam int AW = $clog2(BUF_DEPTH);
    localparam int CW = $clog2(BUF_DEPTH) + 1;
    localparam int RW = (NUM_VAR > 1) ? $clog2(NUM_VAR) : 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    pipe_t               r_mem [NUM_VAR][BUF_DEPTH];
    logic [AW-1:0]       r_wr_ptr [NUM_VAR];
    logic [AW-1:0]       r_rd_ptr [NUM_VAR];
    logic [CW-1:0]       r_cnt [NUM_VAR];
    logic [RW-1:0]       r_rr_ptr;
    logic [SW-1:0]       r_starve;
    logic                r_conflict;

    pipe_t               w_head [NUM_VAR];
    pipe_t               w_wb [NUM_WB];
    logic [NUM_VAR-1:0]  w_empty;
    logic [NUM_VAR-1:0]  w_full;
    logic [NUM_VAR-1:0]  w_req;
    logic [NUM_VAR-1:0]  w_push;
    logic [NUM_VAR-1:0]  w_pop;
    logic                w_fix_over;
    logic                w_var_grant;
    logic [RW-1:0]       w_next_rr;
    logic                w_any_pending;
    logic                w_fifo_high;
    logic                w_starve_hit;

    // Handshake: a variable channel transfers on a clock edge where valid&wren and o_var_ready
    // are both high; a refused request is held stable by the producer until accepted.
    always_comb begin
        w_any_pending = 1'b0;
        w_fifo_high   = 1'b0;
        for (int c = 0; c < NUM_VAR; c++) begin
            w_head[c]  = r_mem[c][r_rd_ptr[c]];
            w_empty[c] = (r_cnt[c] == '0);
            w_full[c]  = (r_cnt[c] == CW'(BUF_DEPTH));
            w_req[c]   = i_var_pkg[c].valid & i_var_pkg[c].wren;
            if (!w_empty[c]) w_any_pending = 1'b1;
            if (r_cnt[c] >= CW'(BUF_DEPTH - 1)) w_fifo_high = 1'b1;
        end
    end

    assign o_var_ready  = ~w_full & {NUM_VAR{~i_rst}};
    assign w_push       = w_req & o_var_ready;
    assign w_starve_hit = (r_starve == SW'(STARVE_LIMIT));
    assign o_stall      = w_starve_hit | w_fifo_high;
    assign o_conflict   = r_conflict;
    assign o_wb_pkg     = w_wb;

    // Port allocation: fixed requests first in channel order, then FIFO heads from r_rr_ptr.
    always_comb begin
        int n_used;
        int ch;
        w_wb        = '{default: '0};
        w_pop       = '0;
        w_fix_over  = 1'b0;
        w_var_grant = 1'b0;
        w_next_rr   = r_rr_ptr;
        n_used      = 0;
        ch          = 0;
        for (int f = 0; f < NUM_FIX; f++) begin
            if (i_fix_pkg[f].valid && i_fix_pkg[f].wren) begin
                if (n_used < NUM_WB) begin
                    for (int p = 0; p < NUM_WB; p++)
                        if (p == n_used) w_wb[p] = i_fix_pkg[f];
                    n_used = n_used + 1;
                end else begin
                    w_fix_over = 1'b1;
                end
            end
        end
        for (int k = 0; k < NUM_VAR; k++) begin
            ch = (int'(r_rr_ptr) + k) % NUM_VAR;
            for (int c = 0; c < NUM_VAR; c++) begin
                if (c == ch && !w_empty[c] && n_used < NUM_WB) begin
                    for (int p = 0; p < NUM_WB; p++)
                        if (p == n_used) w_wb[p] = w_head[c];
                    n_used      = n_used + 1;
                    w_pop[c]    = 1'b1;
                    w_var_grant = 1'b1;
                    w_next_rr   = RW'((c + 1) % NUM_VAR);
                end
            end
        end
        // Nothing leaves the arbiter while reset is held.
        if (i_rst) begin
            w_wb        = '{default: '0};
            w_pop       = '0;
            w_fix_over  = 1'b0;
            w_var_grant = 1'b0;
            w_next_rr   = r_rr_ptr;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int c = 0; c < NUM_VAR; c++) begin
                r_wr_ptr[c] <= '0;
                r_rd_ptr[c] <= '0;
                r_cnt[c]    <= '0;
            end
            r_rr_ptr   <= '0;
            r_starve   <= '0;
            r_conflict <= 1'b0;
        end else begin
            for (int c = 0; c < NUM_VAR; c++) begin
                if (w_push[c]) begin
                    r_mem[c][r_wr_ptr[c]] <= i_var_pkg[c];
                    r_wr_ptr[c]           <= r_wr_ptr[c] + 1'b1;
                end
                if (w_pop[c]) r_rd_ptr[c] <= r_rd_ptr[c] + 1'b1;
                case ({w_push[c], w_pop[c]})
                    2'b10:   r_cnt[c] <= r_cnt[c] + 1'b1;
                    2'b01:   r_cnt[c] <= r_cnt[c] - 1'b1;
                    default: r_cnt[c] <= r_cnt[c];
                endcase
            end
            r_rr_ptr <= w_next_rr;
            if (!w_any_pending || w_var_grant) begin
                r_starve <= '0;
            end else if (!w_starve_hit) begin
                r_starve <= r_starve + 1'b1;
            end
            if (w_fix_over) r_conflict <= 1'b1;
        end
    end

`ifdef WB_ARB_PERF_EN
    logic [31:0] r_perf_stall_cnt;
    logic [31:0] r_perf_starve_cnt;
    logic        r_starve_prev;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_perf_stall_cnt  <= '0;
            r_perf_starve_cnt <= '0;
            r_starve_prev     <= 1'b0;
        end else begin
            r_starve_prev <= w_starve_hit;
            if (o_stall) r_perf_stall_cnt <= r_perf_stall_cnt + 32'd1;
            if (w_starve_hit && !r_starve_prev) r_perf_starve_cnt <= r_perf_starve_cnt + 32'd1;
        end
    end

    assign o_perf_stall_cnt  = r_perf_stall_cnt;
    assign o_perf_starve_cnt = r_perf_starve_cnt;
`endif

endmodule

// File: tb/tb_wb_arbiter_rr.sv
// Directed bench for wb_arbiter_rr: a single-port instance (depth 2) and a dual-port
// instance (depth 4) share stimulus; each check targets the instance the scenario is about.
`timescale 1ns/1ps
module tb_wb_arbiter_rr;
    import wb_arbiter_rr_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    pipe_t      fix_pkg [2];
    pipe_t      var_pkg [3];
    pipe_t      wb_a [1];
    pipe_t      wb_b [2];
    logic [2:0] rdy_a;
    logic [2:0] rdy_b;
    logic       stall_a;
    logic       stall_b;
    logic       conf_a;
    logic       conf_b;
`ifdef WB_ARB_PERF_EN
    logic [31:0] ps_a;
    logic [31:0] pv_a;
    logic [31:0] ps_b;
    logic [31:0] pv_b;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    logic [$bits(pipe_t)-1:0] exp_q[$];

    always #5 clk = ~clk;

    wb_arbiter_rr #(.NUM_FIX(2), .NUM_VAR(3), .NUM_WB(1), .BUF_DEPTH(2), .STARVE_LIMIT(4)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_fix_pkg(fix_pkg), .i_var_pkg(var_pkg),
        .o_var_ready(rdy_a), .o_wb_pkg(wb_a), .o_stall(stall_a), .o_conflict(conf_a)
`ifdef WB_ARB_PERF_EN
        , .o_perf_stall_cnt(ps_a), .o_perf_starve_cnt(pv_a)
`endif
    );

    wb_arbiter_rr #(.NUM_FIX(2), .NUM_VAR(3), .NUM_WB(2), .BUF_DEPTH(4), .STARVE_LIMIT(4)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_fix_pkg(fix_pkg), .i_var_pkg(var_pkg),
        .o_var_ready(rdy_b), .o_wb_pkg(wb_b), .o_stall(stall_b), .o_conflict(conf_b)
`ifdef WB_ARB_PERF_EN
        , .o_perf_stall_cnt(ps_b), .o_perf_starve_cnt(pv_b)
`endif
    );

    typedef struct {
        pipe_t f0;
        pipe_t f1;
        pipe_t ea0;
        pipe_t eb0;
        pipe_t eb1;
        logic  ca;
    } vec_t;
    vec_t vt [6];

    function automatic pipe_t mk(input logic [4:0] rd, input logic [31:0] d);
        pipe_t p;
        p.valid = 1'b1;
        p.wren  = 1'b1;
        p.rd    = rd;
        p.data  = d;
        return p;
    endfunction

    task automatic chk_pkg(input string name, input pipe_t act, input pipe_t exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        for (int i = 0; i < 2; i++) fix_pkg[i] = '0;
        for (int i = 0; i < 3; i++) var_pkg[i] = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        tick();
        tick();
        rst = 1'b0;
    endtask

    pipe_t z, p_alu, p_bru, p_alu_nw, p_bru2, p_l, p_m, p_d, p_m2, p_m3;

    initial begin
        z        = '0;
        p_alu    = mk(5'd5, 32'hA1A1_0005);
        p_bru    = mk(5'd9, 32'hB2B2_0009);
        p_alu_nw = p_alu;
        p_alu_nw.wren = 1'b0;
        p_bru2   = mk(5'd17, 32'hB2B2_0011);
        p_l      = mk(5'd1, 32'h1111_0001);
        p_m      = mk(5'd2, 32'h2222_0002);
        p_d      = mk(5'd3, 32'h3333_0003);
        p_m2     = mk(5'd12, 32'h2222_000C);
        p_m3     = mk(5'd13, 32'h2222_000D);

        vt[0] = '{p_alu,    z,      p_alu,  p_alu,  z,     1'b0};
        vt[1] = '{z,        p_bru,  p_bru,  p_bru,  z,     1'b0};
        vt[2] = '{p_alu_nw, z,      z,      z,      z,     1'b0};
        vt[3] = '{p_alu_nw, p_bru2, p_bru2, p_bru2, z,     1'b0};
        vt[4] = '{p_alu,    p_bru,  p_alu,  p_alu,  p_bru, 1'b1};
        vt[5] = '{z,        z,      z,      z,      z,     1'b1};

        // Reset values, with an ALU request driven to show the port stays idle.
        rst = 1'b1;
        idle_inputs();
        tick();
        fix_pkg[0] = p_alu;
        #1;
        chk_pkg("rst_wb_idle", wb_a[0], z);
        chk_val("rst_ready", 32'(rdy_a), 32'h0);
        tick();
        chk_val("rst_stall", 32'(stall_a), 32'h0);
        chk_val("rst_conflict", 32'(conf_a), 32'h0);
        rst = 1'b0;
        idle_inputs();
        #1;
        chk_val("post_rst_ready", 32'(rdy_a), 32'h7);

        // Fixed-latency pass-through and conflict table.
        for (int i = 0; i < 6; i++) begin
            fix_pkg[0] = vt[i].f0;
            fix_pkg[1] = vt[i].f1;
            #1;
            chk_pkg($sformatf("tbl%0d_a_wb0", i), wb_a[0], vt[i].ea0);
            chk_pkg($sformatf("tbl%0d_b_wb0", i), wb_b[0], vt[i].eb0);
            chk_pkg($sformatf("tbl%0d_b_wb1", i), wb_b[1], vt[i].eb1);
            chk_val($sformatf("tbl%0d_a_ready", i), 32'(rdy_a), 32'h7);
            tick();
            chk_val($sformatf("tbl%0d_a_conflict", i), 32'(conf_a), 32'(vt[i].ca));
            chk_val($sformatf("tbl%0d_b_conflict", i), 32'(conf_b), 32'h0);
        end

        // Round-robin: one package per var channel in the same cycle, twice.
        do_reset();
        for (int r = 0; r < 2; r++) begin
            var_pkg[0] = p_l;
            var_pkg[1] = p_m;
            var_pkg[2] = p_d;
            #1;
            chk_pkg("rr_no_bypass", wb_a[0], z);
            exp_q.push_back(p_l);
            exp_q.push_back(p_m);
            exp_q.push_back(p_d);
            tick();
            idle_inputs();
            for (int c = 0; c < 3; c++) begin
                #1;
                chk_pkg($sformatf("rr%0d_order%0d", r, c), wb_a[0], exp_q.pop_front());
                tick();
            end
            chk_pkg($sformatf("rr%0d_drained", r), wb_a[0], z);
        end

        // Back-pressure on the depth-2 instance while the ALU owns the port.
        do_reset();
        fix_pkg[0] = p_alu;
        var_pkg[1] = p_m;
        #1;
        chk_val("bp_ready_0", 32'(rdy_a[1]), 32'h1);
        tick();
        var_pkg[1] = p_m2;
        chk_val("bp_stall_1st", 32'(stall_a), 32'h1);
        chk_val("bp_ready_1", 32'(rdy_a[1]), 32'h1);
        tick();
        var_pkg[1] = p_m3;
        chk_val("bp_ready_full", 32'(rdy_a[1]), 32'h0);
        #1;
        chk_pkg("bp_alu_wins", wb_a[0], p_alu);
        tick();
        chk_val("bp_held", 32'(rdy_a[1]), 32'h0);
        fix_pkg[0] = z;
        #1;
        chk_pkg("bp_drain_1", wb_a[0], p_m);
        tick();
        chk_val("bp_ready_again", 32'(rdy_a[1]), 32'h1);
        chk_pkg("bp_drain_2", wb_a[0], p_m2);
        tick();
        var_pkg[1] = z;
        #1;
        chk_pkg("bp_drain_3", wb_a[0], p_m3);
        tick();
        chk_pkg("bp_empty", wb_a[0], z);
        chk_val("bp_stall_clear", 32'(stall_a), 32'h0);

        // Starvation on the dual-port instance: both fixed units hold the ports.
        do_reset();
        fix_pkg[0] = p_alu;
        fix_pkg[1] = p_bru;
        var_pkg[2] = p_d;
        #1;
        tick();
        var_pkg[2] = z;
        for (int k = 0; k < 4; k++) begin
            chk_val($sformatf("starve_low_%0d", k), 32'(stall_b), 32'h0);
            tick();
        end
        chk_val("starve_rise", 32'(stall_b), 32'h1);
        tick();
        chk_val("starve_sat", 32'(stall_b), 32'h1);
        fix_pkg[0] = z;
        fix_pkg[1] = z;
        #1;
        chk_pkg("starve_grant", wb_b[0], p_d);
        chk_val("starve_grant_stall", 32'(stall_b), 32'h1);
        tick();
        chk_val("starve_fall", 32'(stall_b), 32'h0);
        chk_pkg("starve_idle", wb_b[0], z);
`ifdef WB_ARB_PERF_EN
        chk_val("perf_stall_cnt", ps_b, 32'd2);
        chk_val("perf_starve_cnt", pv_b, 32'd1);
`endif

        // Multi-port allocation versus conflict on the single-port instance.
        do_reset();
        var_pkg[0] = p_l;
        #1;
        tick();
        var_pkg[0] = z;
        fix_pkg[0] = p_alu;
        fix_pkg[1] = p_bru;
        #1;
        chk_pkg("mp_b_port0", wb_b[0], p_alu);
        chk_pkg("mp_b_port1", wb_b[1], p_bru);
        chk_pkg("mp_a_port0", wb_a[0], p_alu);
        tick();
        chk_val("mp_b_no_conflict", 32'(conf_b), 32'h0);
        chk_val("mp_a_conflict", 32'(conf_a), 32'h1);
        fix_pkg[0] = z;
        fix_pkg[1] = z;
        #1;
        chk_pkg("mp_lsu_waited", wb_b[0], p_l);
        tick();
        for (int k = 0; k < 3; k++) begin
            chk_val($sformatf("conflict_sticky_%0d", k), 32'(conf_a), 32'h1);
            tick();
        end

        // Reset pulse with two packages buffered behind the ALU.
        fix_pkg[0] = p_alu;
        var_pkg[0] = p_l;
        var_pkg[1] = p_m;
        #1;
        tick();
        var_pkg[0] = z;
        var_pkg[1] = z;
        tick();
        rst = 1'b1;
        #1;
        chk_pkg("mid_rst_wb", wb_a[0], z);
        chk_val("mid_rst_ready", 32'(rdy_a), 32'h0);
        tick();
        rst = 1'b0;
        fix_pkg[0] = z;
        chk_val("mid_rst_conflict", 32'(conf_a), 32'h0);
        chk_val("mid_rst_stall", 32'(stall_a), 32'h0);
`ifdef WB_ARB_PERF_EN
        chk_val("mid_rst_perf_stall", ps_a, 32'd0);
        chk_val("mid_rst_perf_starve", pv_a, 32'd0);
`endif
        for (int k = 0; k < 3; k++) begin
            #1;
            chk_pkg($sformatf("mid_rst_flushed_%0d", k), wb_a[0], z);
            tick();
        end
        chk_val("mid_rst_ready_after", 32'(rdy_a), 32'h7);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
